// File: rtl/serial_addsub_pkg.sv
// Shared constants for the bit-serial add/sub sequencer.
// Provides the state encoding, the op select values and the FSM state type.
package serial_addsub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/Full_adder.sv
// One-bit full-adder cell used as the serial datapath.
// Ports: a, b, ci -> s (sum), co (carry out).
module Full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/sub sequencer: one full adder stepped LSB first.
// Ports: clk, rst_n, start/sub/a/b in; busy, done, s, co, ovf out.
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PREV = CW'(WIDTH - 2);

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic             c_msb_in;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;

  Full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == CNT_LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      cnt      <= '0;
      s        <= '0;
      co       <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            // subtract as a + ~b + 1, the +1 entering as carry-in
            b_sh  <= (sub == OP_SUB) ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            s     <= '0;
          end
        end
        RUN: begin
          s     <= {fa_s, s[WIDTH-1:1]};
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_co;
          if (cnt != CNT_LAST)
            cnt <= cnt + 1'b1;
          if (cnt == CNT_PREV)
            c_msb_in <= fa_co;
          if (cnt == CNT_LAST) begin
            co  <= fa_co;
            ovf <= c_msb_in ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl (WIDTH=8).
// Directed and random ops checked against an arithmetic model.
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op_sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (op_sub),
    .a     (op_a),
    .b     (op_b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // returns {ovf, co, s[7:0]}
  function automatic logic [9:0] model(input logic [7:0] x,
                                       input logic [7:0] y,
                                       input logic op);
    logic [7:0] yy;
    logic [8:0] r;
    logic       v;
    yy = op ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + {8'd0, op};
    v  = (x[7] == yy[7]) && (r[7] != x[7]);
    return {v, r};
  endfunction

  task automatic do_op(input logic [7:0] x, input logic [7:0] y,
                       input logic op, input int poke);
    logic [9:0] exp;
    int n_done;
    int n_busy;
    int lat;
    exp = model(x, y, op);
    @(negedge clk);
    op_a = x; op_b = y; op_sub = op; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a = 8'($urandom); op_b = 8'($urandom); op_sub = 1'($urandom);
    n_done = 0; n_busy = 0; lat = 0;
    for (int i = 1; i <= W + 4; i++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (lat == 0) lat = i;
        check("s",   32'(s),   32'(exp[7:0]));
        check("co",  32'(co),  32'(exp[8]));
        check("ovf", 32'(ovf), 32'(exp[9]));
      end
      if (i == poke) begin
        start = 1'b1; op_a = 8'hAA; op_b = 8'h55;
      end else begin
        start = 1'b0;
      end
    end
    check("latency", 32'(lat),    32'(W + 1));
    check("n_done",  32'(n_done), 32'd1);
    check("n_busy",  32'(n_busy), 32'(W + 1));
    check("s_hold",  32'(s),      32'(exp[7:0]));
  endtask

  logic [7:0] ra [50];
  logic [7:0] rb [50];
  logic       rs [50];
  logic [9:0] e;
  int         stray;

  initial begin
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0;
    op_a = '0; op_b = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s",    32'(s),    32'd0);
    check("rst_co",   32'(co),   32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h35, 8'h4A, 1'b0, 0);
    do_op(8'h7F, 8'h01, 1'b0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 0);
    do_op(8'h10, 8'h20, 1'b1, 0);
    do_op(8'h80, 8'h01, 1'b1, 0);
    do_op(8'h01, 8'h02, 1'b0, 3);

    // reset mid-op
    @(negedge clk);
    op_a = 8'hF0; op_b = 8'h0F; op_sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_s",    32'(s),    32'd0);
    check("mid_co",   32'(co),   32'd0);
    check("mid_ovf",  32'(ovf),  32'd0);
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) stray++;
    end
    rst_n = 1'b1;
    repeat (W + 3) begin
      @(negedge clk);
      if (done) stray++;
    end
    check("mid_nodone", 32'(stray), 32'd0);
    do_op(8'h02, 8'h03, 1'b0, 0);

    for (int k = 0; k < 20; k++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 0);

    // back-to-back with start held high
    stray = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (n % 10 == 9) begin
        e = model(ra[n-9], rb[n-9], rs[n-9]);
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_s",    32'(s),    32'(e[7:0]));
        check("b2b_co",   32'(co),   32'(e[8]));
        check("b2b_ovf",  32'(ovf),  32'(e[9]));
      end else if (done) begin
        stray++;
      end
      ra[n] = 8'($urandom); rb[n] = 8'($urandom); rs[n] = 1'($urandom);
      op_a = ra[n]; op_b = rb[n]; op_sub = rs[n]; start = 1'b1;
    end
    start = 1'b0;
    repeat (W + 3) @(negedge clk);
    check("b2b_stray", 32'(stray), 32'd0);
    check("b2b_idle",  32'(busy),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
